interrupt_sequencer: RTL and testbench

- Arbitrates and sequences 6502 interrupt service for the NES CPU core: power-on/reset, NMI (PPU vblank, edge-triggered), IRQ (APU/mapper wired-OR, level) and BRK.
- Captures NMI falling edges into a sticky pending latch, polls sources at instruction boundaries, and hands the CPU a request, a type and the vector address.
- Resolves NMI hijack of BRK/IRQ, and clears each pending source only when the CPU commits to its vector fetch.

---
 rtl/interrupt_sequencer.sv | 149 ++++++++++++++
 tb/tb_interrupt_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// 6502 interrupt sequencer: latches NMI edges, polls IRQ/BRK at instruction boundaries,
// runs reset service, and lets a late NMI hijack an in-flight BRK/IRQ before its vector fetch.
module interrupt_sequencer #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] NMI_VECTOR  = 16'hFFFA,
  parameter logic [15:0] RST_VECTOR  = 16'hFFFC,
  parameter logic [15:0] IRQ_VECTOR  = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        i_flag,
  input  logic        poll,
  input  logic        brk,
  input  logic        vec_fetch,
  output logic        int_req,
  output logic [1:0]  int_type,
  output logic        b_flag,
  output logic [15:0] vector_addr,
  output logic        nmi_pending
);

  localparam logic [1:0] TYPE_NONE = 2'd0;
  localparam logic [1:0] TYPE_RST  = 2'd1;
  localparam logic [1:0] TYPE_NMI  = 2'd2;
  localparam logic [1:0] TYPE_IRQ  = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t     state, state_nx;
  logic       nmi_sync, irq_sync;
  logic       prev_nmi;
  logic       rst_pending;
  logic       nmi_set, irq_active;
  logic       req_nx, b_nx, nmi_clr, rst_clr;
  logic [1:0] type_nx;

  // Input synchronisers, idle-high so reset never fabricates an NMI edge
  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign nmi_sync = nmi_n;
      assign irq_sync = irq_n;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] nmi_meta, irq_meta;
      always_ff @(posedge clk) begin
        if (reset) begin
          nmi_meta <= '1;
          irq_meta <= '1;
        end else begin
          nmi_meta[0] <= nmi_n;
          irq_meta[0] <= irq_n;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            nmi_meta[i] <= nmi_meta[i-1];
            irq_meta[i] <= irq_meta[i-1];
          end
        end
      end
      assign nmi_sync = nmi_meta[SYNC_STAGES-1];
      assign irq_sync = irq_meta[SYNC_STAGES-1];
    end
  endgenerate

  assign nmi_set    = prev_nmi & ~nmi_sync;
  assign irq_active = ~irq_sync & ~i_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_nmi    <= 1'b1;
      nmi_pending <= 1'b0;
      rst_pending <= 1'b1;
      state       <= IDLE;
      int_req     <= 1'b0;
      int_type    <= TYPE_NONE;
      b_flag      <= 1'b0;
    end else begin
      prev_nmi <= nmi_sync;
      // A fresh edge beats a same-cycle clear so back-to-back NMIs are not lost
      if (nmi_set)      nmi_pending <= 1'b1;
      else if (nmi_clr) nmi_pending <= 1'b0;
      if (rst_clr) rst_pending <= 1'b0;
      state    <= state_nx;
      int_req  <= req_nx;
      int_type <= type_nx;
      b_flag   <= b_nx;
    end
  end

  always_comb begin
    state_nx = state;
    req_nx   = int_req;
    type_nx  = int_type;
    b_nx     = b_flag;
    nmi_clr  = 1'b0;
    rst_clr  = 1'b0;
    case (state)
      IDLE: begin
        req_nx  = 1'b0;
        type_nx = TYPE_NONE;
        b_nx    = 1'b0;
        if (rst_pending) begin
          state_nx = REQ;
          req_nx   = 1'b1;
          type_nx  = TYPE_RST;
        end else if (poll) begin
          if (nmi_pending) begin
            state_nx = REQ;
            req_nx   = 1'b1;
            type_nx  = TYPE_NMI;
          end else if (irq_active || brk) begin
            state_nx = REQ;
            req_nx   = 1'b1;
            // An edge latching on this same boundary hijacks from the first REQ cycle
            type_nx  = nmi_set ? TYPE_NMI : TYPE_IRQ;
            b_nx     = ~irq_active;
          end
        end
      end
      REQ: begin
        if (vec_fetch) begin
          state_nx = DONE;
          req_nx   = 1'b0;
          type_nx  = TYPE_NONE;
          b_nx     = 1'b0;
          rst_clr  = (int_type == TYPE_RST);
          nmi_clr  = (int_type == TYPE_NMI);
        end else if (int_type == TYPE_IRQ && (nmi_pending || nmi_set)) begin
          type_nx = TYPE_NMI;
        end
      end
      DONE: begin
        state_nx = IDLE;
        req_nx   = 1'b0;
        type_nx  = TYPE_NONE;
        b_nx     = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    case (int_type)
      TYPE_RST: vector_addr = RST_VECTOR;
      TYPE_NMI: vector_addr = NMI_VECTOR;
      default:  vector_addr = IRQ_VECTOR;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: stimulus predicts service records from an
// event-level model of NMI edges and poll priority; a negedge monitor pops and compares.
module tb_interrupt_sequencer;

  localparam int SYNC = 2;
  localparam int NONE = -100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        nmi_n = 1'b1;
  logic        irq_n = 1'b1;
  logic        i_flag = 1'b1;
  logic        poll = 1'b0;
  logic        brk = 1'b0;
  logic        vec_fetch = 1'b0;
  logic        int_req;
  logic [1:0]  int_type;
  logic        b_flag;
  logic [15:0] vector_addr;
  logic        nmi_pending;

  typedef struct {
    int         cyc;
    logic [1:0] typ;
    logic       b;
    logic       pend;
  } exp_t;

  exp_t start_q[$];
  exp_t commit_q[$];
  int   nmi_sched[$];
  int   len_q[$];
  int   vis_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   nmi_len = 2;
  int   nmi_free_at = 0;
  int   rise_at = -1;

  interrupt_sequencer #(
    .SYNC_STAGES(SYNC),
    .NMI_VECTOR (16'hFFFA),
    .RST_VECTOR (16'hFFFC),
    .IRQ_VECTOR (16'hFFFE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .nmi_n      (nmi_n),
    .irq_n      (irq_n),
    .i_flag     (i_flag),
    .poll       (poll),
    .brk        (brk),
    .vec_fetch  (vec_fetch),
    .int_req    (int_req),
    .int_type   (int_type),
    .b_flag     (b_flag),
    .vector_addr(vector_addr),
    .nmi_pending(nmi_pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] vec_of(input logic [1:0] t);
    case (t)
      2'd1:    return 16'hFFFC;
      2'd2:    return 16'hFFFA;
      default: return 16'hFFFE;
    endcase
  endfunction

  // NMI latched as seen in cycle c: some unconsumed edge has become visible by then
  function automatic logic pend_at(input int c);
    return (vis_q.size() != 0) && (vis_q[0] <= c);
  endfunction

  task automatic consume(input int c);
    while (vis_q.size() != 0 && vis_q[0] <= c) void'(vis_q.pop_front());
  endtask

  task automatic sched_nmi(input int at);
    if (at > cyc && at >= nmi_free_at) begin
      nmi_sched.push_back(at);
      len_q.push_back(nmi_len);
      nmi_free_at = at + nmi_len + 2;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (nmi_sched.size() != 0 && nmi_sched[0] == cyc) begin
      void'(nmi_sched.pop_front());
      rise_at = cyc + len_q.pop_front();
      nmi_n = 1'b0;
      vis_q.push_back(cyc + SYNC + 1);
    end else if (cyc == rise_at) begin
      nmi_n = 1'b1;
    end
    chk("nmi_pending", 32'(nmi_pending), 32'(pend_at(cyc)));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic push_start(input logic [1:0] sel, input logic bsel);
    exp_t e;
    e.cyc  = cyc + 1;
    e.typ  = (sel == 2'd3 && pend_at(cyc + 1)) ? 2'd2 : sel;
    e.b    = bsel;
    e.pend = 1'b0;
    start_q.push_back(e);
  endtask

  // Run the REQ phase (stray polls are ignored by the DUT) and commit with vec_fetch
  task automatic finish(input logic [1:0] sel, input logic bsel, input int gap);
    exp_t e;
    for (int i = 0; i < gap; i++) begin
      step();
      poll = ($urandom_range(0, 3) == 0);
      brk  = 1'($urandom_range(0, 1));
    end
    e.cyc = cyc;
    e.typ = (sel == 2'd3 && pend_at(cyc)) ? 2'd2 : sel;
    e.b   = bsel;
    if (e.typ == 2'd2) consume(cyc);
    e.pend = pend_at(cyc + 1);
    commit_q.push_back(e);
    vec_fetch = 1'b1;
    step();
    vec_fetch = 1'b0;
    poll = 1'($urandom_range(0, 1));
    brk  = 1'($urandom_range(0, 1));
    step();
    poll = 1'b0;
    brk  = 1'b0;
  endtask

  task automatic do_reset(input int gap);
    nmi_sched.delete();
    len_q.delete();
    vis_q.delete();
    rise_at   = -1;
    nmi_n     = 1'b1;
    poll      = 1'b0;
    brk       = 1'b0;
    vec_fetch = 1'b0;
    reset     = 1'b1;
    repeat (3) begin
      step();
      chk("reset_int_req", 32'(int_req), 32'd0);
      chk("reset_b_flag", 32'(b_flag), 32'd0);
    end
    nmi_free_at = cyc + 2;
    reset = 1'b0;
    push_start(2'd1, 1'b0);
    finish(2'd1, 1'b0, gap);
  endtask

  task automatic txn(input logic brk_v, input int gap, input int rel1, input int rel2,
                     input logic abort);
    int         p;
    logic [1:0] sel;
    logic       bsel;
    logic       irq_act;
    p = cyc + 8;
    if (rel1 != NONE) sched_nmi(p + rel1);
    if (rel2 != NONE) sched_nmi(p + rel2);
    idle_cycles(8);
    irq_act = !irq_n && !i_flag;
    sel  = 2'd0;
    bsel = 1'b0;
    if (pend_at(cyc))  sel = 2'd2;
    else if (irq_act)  sel = 2'd3;
    else if (brk_v) begin
      sel  = 2'd3;
      bsel = 1'b1;
    end
    poll = 1'b1;
    brk  = brk_v;
    if (sel == 2'd0) begin
      repeat (2) begin
        step();
        poll = 1'b0;
        brk  = 1'b0;
        chk("idle_no_req", 32'(int_req), 32'd0);
      end
    end else begin
      push_start(sel, bsel);
      if (abort) begin
        step();
        poll = 1'b0;
        brk  = 1'b0;
        step();
        do_reset(2);
      end else begin
        finish(sel, bsel, gap);
      end
    end
  endtask

  // Monitor: a rising int_req must match the next start record; a vec_fetch in REQ
  // must match the next commit record, and the following cycle must be idle.
  initial begin
    exp_t e;
    logic req_d;
    logic after;
    logic pend_exp;
    req_d    = 1'b0;
    after    = 1'b0;
    pend_exp = 1'b0;
    forever begin
      @(negedge clk);
      if (after) begin
        chk("fetch_drop_req", 32'(int_req), 32'd0);
        chk("done_type", 32'(int_type), 32'd0);
        chk("done_b_flag", 32'(b_flag), 32'd0);
        chk("pend_after_fetch", 32'(nmi_pending), 32'(pend_exp));
        after = 1'b0;
      end
      if (int_req === 1'b1 && req_d !== 1'b1) begin
        chk("req_expected", 32'(start_q.size() != 0), 32'd1);
        if (start_q.size() != 0) begin
          e = start_q.pop_front();
          chk("start_cycle", cyc, e.cyc);
          chk("start_type", 32'(int_type), 32'(e.typ));
          chk("start_b_flag", 32'(b_flag), 32'(e.b));
          chk("start_vector", 32'(vector_addr), 32'(vec_of(e.typ)));
        end
      end
      if (int_req === 1'b1 && vec_fetch === 1'b1) begin
        chk("commit_expected", 32'(commit_q.size() != 0), 32'd1);
        if (commit_q.size() != 0) begin
          e = commit_q.pop_front();
          chk("commit_cycle", cyc, e.cyc);
          chk("commit_type", 32'(int_type), 32'(e.typ));
          chk("commit_b_flag", 32'(b_flag), 32'(e.b));
          chk("commit_vector", 32'(vector_addr), 32'(vec_of(e.typ)));
          pend_exp = e.pend;
          after    = 1'b1;
        end
      end
      req_d = int_req;
    end
  end

  initial begin
    do_reset(2);
    irq_n  = 1'b1;
    i_flag = 1'b1;
    txn(1'b0, 1, NONE, NONE, 1'b0);

    // nmi_n held low for 100 cycles yields exactly one service
    nmi_len = 100;
    sched_nmi(cyc + 1);
    nmi_len = 2;
    idle_cycles(60);
    txn(1'b0, 2, NONE, NONE, 1'b0);
    txn(1'b0, 2, NONE, NONE, 1'b0);
    idle_cycles(50);

    // IRQ masked, unmasked, then released before poll
    irq_n  = 1'b0;
    i_flag = 1'b1;
    txn(1'b0, 1, NONE, NONE, 1'b0);
    i_flag = 1'b0;
    txn(1'b0, 3, NONE, NONE, 1'b0);
    idle_cycles(3);
    irq_n = 1'b1;
    txn(1'b0, 1, NONE, NONE, 1'b0);
    i_flag = 1'b1;

    // BRK hijacked by an NMI arriving two cycles after poll
    txn(1'b1, 7, 2, NONE, 1'b0);

    // Second NMI edge latches on the same edge that clears the first
    txn(1'b0, 4, -6, 2, 1'b0);
    txn(1'b0, 2, NONE, NONE, 1'b0);

    // NMI and IRQ at the same poll: NMI first, IRQ next
    irq_n  = 1'b0;
    i_flag = 1'b0;
    txn(1'b0, 2, -5, NONE, 1'b0);
    txn(1'b0, 2, NONE, NONE, 1'b0);
    irq_n  = 1'b1;
    i_flag = 1'b1;

    // Stray vec_fetch in IDLE must not clear a pending NMI
    sched_nmi(cyc + 1);
    idle_cycles(6);
    vec_fetch = 1'b1;
    step();
    vec_fetch = 1'b0;
    txn(1'b0, 2, NONE, NONE, 1'b0);

    // Reset during REQ discards the NMI latch and restarts reset service
    txn(1'b0, 2, -5, NONE, 1'b1);

    for (int t = 0; t < 40; t++) begin
      int   r1;
      int   r2;
      logic ab;
      irq_n  = ($urandom_range(0, 2) != 0);
      i_flag = 1'($urandom_range(0, 1));
      r1 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 12)) - 7 : NONE;
      r2 = (r1 != NONE && $urandom_range(0, 3) == 0) ? r1 + 4 + int'($urandom_range(0, 3)) : NONE;
      ab = ($urandom_range(0, 9) == 0);
      txn(1'($urandom_range(0, 1)), int'($urandom_range(1, 6)), r1, r2, ab);
    end

    idle_cycles(5);
    chk("start_q_drained", 32'(start_q.size()), 32'd0);
    chk("commit_q_drained", 32'(commit_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
